radix4_booth_csa_mult: RTL and testbench

RADIX4_BOOTH_CSA_MULT -- requirements
Module: radix4_booth_csa_mult

---
 rtl/booth_pkg.sv | 41 ++++
 rtl/csa_3to2.sv | 18 +
 rtl/radix4_booth_csa_mult.sv | 135 +++++++++++++
 tb/tb_radix4_booth_csa_mult.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared types for the radix-4 Booth carry-save multiplier.
//   state_e       : control FSM states (IDLE, CALC, DONE)
//   booth_mag_e   : magnitude select of one Booth digit (0, 1 or 2 times A)
//   booth_digit_t : sign plus magnitude of one radix-4 Booth digit
//   booth_decode  : maps the overlapping triple {b[2i+1], b[2i], b[2i-1]} to a digit
package booth_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    MAG_ZERO = 2'd0,
    MAG_ONE  = 2'd1,
    MAG_TWO  = 2'd2
  } booth_mag_e;

  typedef struct packed {
    logic       neg;
    booth_mag_e mag;
  } booth_digit_t;

  // Triple 3'b111 is "-0": it is reported as a plain zero (neg=0) so that no
  // spurious +1 is injected into the carry vector.
  function automatic booth_digit_t booth_decode(input logic [2:0] triple);
    booth_digit_t d;
    d.neg = 1'b0;
    d.mag = MAG_ZERO;
    case (triple)
      3'b001, 3'b010: begin d.neg = 1'b0; d.mag = MAG_ONE;  end
      3'b011:         begin d.neg = 1'b0; d.mag = MAG_TWO;  end
      3'b100:         begin d.neg = 1'b1; d.mag = MAG_TWO;  end
      3'b101, 3'b110: begin d.neg = 1'b1; d.mag = MAG_ONE;  end
      default:        begin d.neg = 1'b0; d.mag = MAG_ZERO; end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/csa_3to2.sv
// 3:2 carry-save compressor, bitwise full adders without carry propagation.
//   x, y, z : three BITS-wide addends
//   s       : bitwise sum  (x ^ y ^ z)
//   c       : bitwise majority, NOT shifted; the caller aligns it by one bit
module csa_3to2 #(
  parameter int BITS = 32
) (
  input  logic [BITS-1:0] x,
  input  logic [BITS-1:0] y,
  input  logic [BITS-1:0] z,
  output logic [BITS-1:0] s,
  output logic [BITS-1:0] c
);

  assign s = x ^ y ^ z;
  assign c = (x & y) | (x & z) | (y & z);

endmodule

// File: rtl/radix4_booth_csa_mult.sv
// Sequential radix-4 Booth multiplier that leaves its product in carry-save
// form. One Booth digit is retired per cycle; the final sum/carry pair is
// resolved by a downstream carry-propagate adder.
//   clk, rst_n         : clock (rising edge), synchronous active-low reset
//   in_valid, in_ready : operand handshake, mcand = A, mplier = B (signed)
//   out_valid, out_ready : result handshake
//   sum_o, carry_o     : redundant product, (sum_o + carry_o) mod 2^BITS = A*B
//   state              : current FSM state, for observation only
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. in_ready is 1 only in IDLE, out_valid only in DONE; while out_valid
// is 1 and out_ready is 0 the outputs hold. in_valid outside IDLE is ignored.
module radix4_booth_csa_mult
  import booth_pkg::*;
#(
  parameter int OP_BITS = 16,
  parameter int BITS    = 2 * OP_BITS
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OP_BITS-1:0] mcand,
  input  logic [OP_BITS-1:0] mplier,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BITS-1:0]    sum_o,
  output logic [BITS-1:0]    carry_o,
  output state_e             state
);

  localparam int DIGITS = OP_BITS / 2;
  localparam int CNT_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_I = CNT_W'(DIGITS - 1);

  state_e state_q, state_d;

  logic [CNT_W-1:0] i_q;
  // A sign-extended to BITS and pre-shifted by 2i, so the partial product
  // needs no variable shifter.
  logic [BITS-1:0]  a_q;
  // {B, 1'b0} shifted right by 2 per digit; bits [2:0] are always the
  // current Booth triple {B[2i+1], B[2i], B[2i-1]}.
  logic [OP_BITS:0] b_q;
  logic [BITS-1:0]  sum_q, carry_q;

  booth_digit_t     digit;
  logic [BITS-1:0]  mag_val;
  logic [BITS-1:0]  pp;
  logic [BITS-1:0]  csa_s, csa_c;
  logic [BITS-1:0]  carry_next;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid)      state_d = ST_CALC;
      ST_CALC: if (i_q == LAST_I) state_d = ST_DONE;
      ST_DONE: if (out_ready)     state_d = ST_IDLE;
      default:                    state_d = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
  end

  assign state = state_q;

  // ---------------- datapath ----------------
  always_comb begin
    digit = booth_decode(b_q[2:0]);
    case (digit.mag)
      MAG_ONE: mag_val = a_q;
      MAG_TWO: mag_val = a_q << 1;
      default: mag_val = '0;
    endcase
    // Negation as one's complement here; the +1 goes into carry bit 0.
    pp = digit.neg ? ~mag_val : mag_val;
  end

  csa_3to2 #(.BITS(BITS)) u_csa (
    .x (sum_q),
    .y (carry_q),
    .z (pp),
    .s (csa_s),
    .c (csa_c)
  );

  // Majority shifted into weight 2; the vacated bit 0 carries the +1 that
  // completes the two's-complement negation. The top carry is dropped (mod 2^BITS).
  assign carry_next = (csa_c << 1) | BITS'(digit.neg);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      i_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            a_q     <= BITS'($signed(mcand));
            b_q     <= {mplier, 1'b0};
            sum_q   <= '0;
            carry_q <= '0;
            i_q     <= '0;
          end
        end
        ST_CALC: begin
          sum_q   <= csa_s;
          carry_q <= carry_next;
          a_q     <= a_q << 2;
          b_q     <= b_q >> 2;
          i_q     <= i_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign sum_o   = sum_q;
  assign carry_o = carry_q;

endmodule

// File: tb/tb_radix4_booth_csa_mult.sv
// Directed bench for radix4_booth_csa_mult (OP_BITS=16, BITS=32).
module tb_radix4_booth_csa_mult;
  import booth_pkg::*;

  localparam int OP_BITS = 16;
  localparam int BITS    = 32;
  localparam int LAT     = OP_BITS / 2 + 1;

  logic               clk;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [OP_BITS-1:0] mcand;
  logic [OP_BITS-1:0] mplier;
  logic               out_valid;
  logic               out_ready;
  logic [BITS-1:0]    sum_o;
  logic [BITS-1:0]    carry_o;
  state_e             state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [BITS-1:0] exp_q[$];

  typedef struct {
    logic [OP_BITS-1:0] a;
    logic [OP_BITS-1:0] b;
    logic [BITS-1:0]    exp;
  } vec_t;

  vec_t vecs[13];

  radix4_booth_csa_mult #(.OP_BITS(OP_BITS), .BITS(BITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mcand     (mcand),
    .mplier    (mplier),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum_o     (sum_o),
    .carry_o   (carry_o),
    .state     (state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_idle(input string name);
    check({name, " state"},     64'(state),     64'(ST_IDLE));
    check({name, " in_ready"},  64'(in_ready),  64'd1);
    check({name, " out_valid"}, 64'(out_valid), 64'd0);
    check({name, " sum_o"},     64'(sum_o),     64'd0);
    check({name, " carry_o"},   64'(carry_o),   64'd0);
  endtask

  // Offers one pair, measures latency (edges counted from the accepting edge
  // inclusive), optionally stalls the output while poking in_valid, then
  // compares the resolved product against the queued expectation.
  task automatic run_op(input logic [OP_BITS-1:0] a, input logic [OP_BITS-1:0] b,
                        input logic [BITS-1:0] exp, input int stall, input string name);
    int lat;
    logic [BITS-1:0] s0, c0, got, want;
    check({name, " in_ready before offer"}, 64'(in_ready), 64'd1);
    exp_q.push_back(exp);
    mcand    = a;
    mplier   = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 4 * LAT) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({name, " latency"}, 64'(lat), 64'(LAT));
    s0 = sum_o;
    c0 = carry_o;
    for (int k = 0; k < stall; k++) begin
      in_valid = 1'b1;
      mcand    = OP_BITS'($urandom_range(0, 65535));
      mplier   = OP_BITS'($urandom_range(0, 65535));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check({name, " stall out_valid"}, 64'(out_valid), 64'd1);
      check({name, " stall in_ready"},  64'(in_ready),  64'd0);
      check({name, " stall sum_o"},     64'(sum_o),     64'(s0));
      check({name, " stall carry_o"},   64'(carry_o),   64'(c0));
    end
    got  = sum_o + carry_o;
    want = exp_q.pop_front();
    check({name, " product"}, 64'(got), 64'(want));
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({name, " back to idle"}, 64'(in_ready), 64'd1);
  endtask

  // ---------------- test ----------------
  initial begin
    vecs[0]  = '{16'd3,    16'd5,    32'h0000000F};
    vecs[1]  = '{16'hFFFF, 16'hFFFF, 32'h00000001};
    vecs[2]  = '{16'h8000, 16'h8000, 32'h40000000};
    vecs[3]  = '{16'h7FFF, 16'h8000, 32'hC0008000};
    vecs[4]  = '{16'h0000, 16'h1234, 32'h00000000};
    vecs[5]  = '{16'h0001, 16'hFFFF, 32'hFFFFFFFF};
    vecs[6]  = '{16'h7FFF, 16'h7FFF, 32'h3FFF0001};
    vecs[7]  = '{16'hFFFE, 16'h0003, 32'hFFFFFFFA};
    vecs[8]  = '{16'd100,  16'd200,  32'h00004E20};
    vecs[9]  = '{16'h8000, 16'h0001, 32'hFFFF8000};
    vecs[10] = '{16'h1234, 16'h0010, 32'h00012340};
    vecs[11] = '{16'h0003, 16'hFFFD, 32'hFFFFFFF7};
    vecs[12] = '{16'h8000, 16'h7FFF, 32'hC0008000};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    mcand     = '0;
    mplier    = '0;
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset");
    rst_n = 1'b1;

    // table-driven vectors, first one accepted on the first edge out of reset
    for (int v = 0; v < 13; v++)
      run_op(vecs[v].a, vecs[v].b, vecs[v].exp, 0, $sformatf("vec%0d", v));

    // output stall of 5 cycles with in_valid pokes
    run_op(16'h1234, 16'h5678, 32'h06260060, 5, "stall");
    // follow-up proves the stall pokes were not latched
    run_op(16'd3, 16'd5, 32'h0000000F, 0, "after stall");

    // reset on the fourth CALC cycle
    mcand    = 16'h1234;
    mplier   = 16'h5678;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid-calc state", 64'(state), 64'(ST_CALC));
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_idle("mid-calc reset");
    run_op(16'd7, 16'hFFFA, 32'hFFFFFFD6, 0, "7x-6");

    // random signed pairs with random output stalls
    for (int r = 0; r < 300; r++) begin
      logic signed [OP_BITS-1:0] sa, sb;
      logic signed [BITS-1:0]    p;
      sa = OP_BITS'($urandom_range(0, 65535));
      sb = OP_BITS'($urandom_range(0, 65535));
      p  = sa * sb;
      run_op(sa, sb, p, int'($urandom_range(0, 3)), $sformatf("rand%0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
